// File: rtl/td4_pkg.sv
// td4_pkg: types and widths shared by the TD4 CPU, its program RAM and the program loader.
package td4_pkg;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 2 ** AW;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CSUM,
        DONE,
        ERR
    } loader_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: host byte link plus program RAM write port; master is the host/RAM side, slave the loader.
interface prog_loader_if;
    import td4_pkg::*;

    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;

    modport master (
        output in_data, in_valid,
        input  in_ready, we, waddr, wdata
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, we, waddr, wdata
    );

endinterface

// File: rtl/byte_timer.sv
// byte_timer: counts idle cycles between accepted bytes; expire marks the cycle in which the run reaches LIMIT.
module byte_timer #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    // count holds completed idle cycles, so the current idle cycle is the LIMIT-th when count == LIMIT-1
    assign expire = en && !clr && (count == LAST);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a host program image into the TD4 instruction RAM and releases CPU reset once valid.
// Define CHECKSUM_EN to require a trailing checksum byte: (sum of data + checksum) mod 256 must be zero.
//
// state | meaning
// IDLE  | no image seen since reset; waiting for sync byte
// LOAD  | writing data bytes to RAM addresses 0..DEPTH-1
// CSUM  | waiting for checksum byte (CHECKSUM_EN builds only)
// DONE  | image accepted, CPU released
// ERR   | image aborted by timeout or bad checksum, CPU held
module prog_loader
    import td4_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         TIMEOUT   = 255
) (
    input  logic         clk,
    input  logic         rst,
    prog_loader_if.slave bus,
    output logic         cpu_rstb,
    output logic         done,
    output logic         err
);

    loader_state_t state;
    logic [AW-1:0] count;
    logic          accept;
    logic          in_image;
    logic          is_sync;
    logic          tmr_expire;

`ifdef CHECKSUM_EN
    logic [7:0] sum;
    logic [7:0] sum_next;
    assign sum_next = sum + bus.in_data;
`endif

    assign accept   = bus.in_valid && bus.in_ready;
    assign in_image = (state == LOAD) || (state == CSUM);
    assign is_sync  = (bus.in_data == SYNC_BYTE);

    byte_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept || !in_image),
        .en     (in_image && !accept),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            bus.in_ready <= 1'b1;
            bus.we       <= 1'b0;
            bus.waddr    <= '0;
            bus.wdata    <= '0;
            cpu_rstb     <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
`ifdef CHECKSUM_EN
            sum          <= 8'd0;
`endif
        end else begin
            bus.in_ready <= 1'b1;
            bus.we       <= 1'b0;
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (accept && is_sync) begin
                        state    <= LOAD;
                        count    <= '0;
                        done     <= 1'b0;
                        err      <= 1'b0;
                        cpu_rstb <= 1'b0;
`ifdef CHECKSUM_EN
                        sum      <= 8'd0;
`endif
                    end
                end
                LOAD: begin
                    if (accept) begin
                        bus.we    <= 1'b1;
                        bus.waddr <= count;
                        bus.wdata <= bus.in_data;
                        count     <= count + 1'b1;
`ifdef CHECKSUM_EN
                        sum       <= sum_next;
`endif
                        if (count == AW'(DEPTH - 1)) begin
`ifdef CHECKSUM_EN
                            state    <= CSUM;
`else
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_rstb <= 1'b1;
`endif
                        end
                    end else if (tmr_expire) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        cpu_rstb <= 1'b0;
                    end
                end
`ifdef CHECKSUM_EN
                CSUM: begin
                    if (accept) begin
                        if (sum_next == 8'd0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_rstb <= 1'b1;
                        end else begin
                            state    <= ERR;
                            err      <= 1'b1;
                            cpu_rstb <= 1'b0;
                        end
                    end else if (tmr_expire) begin
                        state    <= ERR;
                        err      <= 1'b1;
                        cpu_rstb <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
